// File: rtl/serial_add_ctrl_if.sv
// Handshake bundle for serial_add_ctrl: operand request channel and result channel.
// Port ovf exists only when OVF_FLAG_EN is defined.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef OVF_FLAG_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Nibble-serial adder: one 4-bit ripple slice reused over WIDTH/4 cycles per operation.
// Optional signed-overflow flag enabled with macro OVF_FLAG_EN.
module serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_add_ctrl_if.slave   bus,
  output logic               busy
);
  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic               in_ready_q, out_valid_q, cout_q, carry_q;
  logic [IDX_W-1:0]   idx_q;
  logic [WIDTH-1:0]   a_q, b_q, sum_q;
  logic [3:0]         a_nib, b_nib;
  logic [5:0]         slc;
  logic               last, accept;

  // Returns {carry into bit 3, carry out of bit 3, 4-bit sum}.
  function automatic logic [5:0] slice4(input logic [3:0] x, input logic [3:0] y,
                                        input logic ci);
    logic [4:0] c;
    logic [3:0] s;
    c[0] = ci;
    for (int i = 0; i < 4; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    return {c[3], c[4], s};
  endfunction

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int n = 0; n < NIB; n++) begin
      if (idx_q == IDX_W'(n)) begin
        a_nib = a_q[4*n +: 4];
        b_nib = b_q[4*n +: 4];
      end
    end
  end

  assign slc    = slice4(a_nib, b_nib, carry_q);
  assign last   = (idx_q == IDX_W'(NIB - 1));
  assign accept = (state == IDLE) && bus.in_valid && in_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)        state_nxt = RUN;
      RUN:     if (last)          state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Operands only matter between accept and DONE, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= bus.a;
      b_q <= bus.b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
    end else begin
      in_ready_q <= (state_nxt == IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            carry_q <= bus.cin;
            idx_q   <= '0;
          end
        end
        RUN: begin
          for (int n = 0; n < NIB; n++)
            if (idx_q == IDX_W'(n)) sum_q[4*n +: 4] <= slc[3:0];
          carry_q <= slc[4];
          if (last) begin
            idx_q       <= '0;
            cout_q      <= slc[4];
            out_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: if (bus.out_ready) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef OVF_FLAG_EN
  logic ovf_q;

  // Signed overflow: carry into the MSB disagrees with carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    ovf_q <= 1'b0;
    else if (state == RUN && last) ovf_q <= slc[5] ^ slc[4];
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign busy          = (state != IDLE);
endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, 16, operand width in bits; SHALL be a multiple of 4 and >= 4; NIB = WIDTH/4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand set a/b/cin offered.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 a  input  WIDTH  addend A.
REQ-007 b  input  WIDTH  addend B.
REQ-008 cin  input  1  carry-in to nibble 0.
REQ-009 out_valid  output  1  sum/cout result available.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 sum  output  WIDTH  result A+B+cin modulo 2^WIDTH.
REQ-012 cout  output  1  carry out of bit WIDTH-1.
REQ-013 busy  output  1  high in RUN and DONE.
REQ-014 ovf  output  1  signed overflow; present only with OVF_FLAG_EN.

Function
REQ-015 One 4-bit ripple-carry slice SHALL be reused for all nibbles; no WIDTH-wide adder.
REQ-016 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-017 in_ready is registered: 1 exactly when the state is IDLE, except it is 0 during reset and rises on the first clk edge after rst_n deasserts.
REQ-018 IDLE: on in_valid & in_ready at an edge, latch a, b; load carry register with cin; load nibble index with 0; go to RUN.
REQ-019 RUN: each cycle, slice adds latched a/b nibble[idx] plus carry register; write the result to sum nibble[idx]; carry register <= slice carry; idx <= idx+1.
REQ-020 RUN: the cycle that processes idx = NIB-1 SHALL go to DONE with cout <= slice carry and out_valid <= 1.
REQ-021 Latency: out_valid SHALL rise exactly NIB clk edges after the accepting edge.
REQ-022 DONE: sum, cout and ovf SHALL be held stable while out_valid=1 & out_ready=0.
REQ-023 DONE: on out_ready=1 at an edge, out_valid <= 0 and the FSM goes to IDLE; sum/cout keep their last values.
REQ-024 Back-to-back: in_ready is 0 in RUN and DONE. Throughput is one operation per NIB+2 cycles.
REQ-025 a, b, cin and in_valid changes SHALL be ignored outside the accepting edge.
REQ-026 out_ready SHALL be ignored outside DONE.
REQ-027 Nibble index wraps to 0 on DONE entry; no index beyond NIB-1 is ever used.
REQ-028 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, in_ready 0, out_valid 0, busy 0, sum 0, cout 0, ovf 0, carry register 0, index 0.
REQ-030 Reset asserted mid-RUN or in DONE aborts the operation; no result SHALL be emitted after release.

Configuration
REQ-031 Macro OVF_FLAG_EN defined: port ovf exists. On the last nibble, ovf <= (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1). ovf is held with sum and cleared only by reset.
REQ-032 Macro OVF_FLAG_EN undefined: port ovf and its logic SHALL be absent; all other behaviour is identical.

Verification (WIDTH=16)
REQ-033 Accept a=0x0001, b=0xFFFF, cin=0 -> out_valid exactly 4 edges later; sum=0x0000, cout=1.
REQ-034 Accept a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0. Change a/b to 0xFFFF during RUN -> result unchanged.
REQ-035 Hold out_ready=0 for 5 cycles in DONE while in_valid=1 -> out_valid, sum and cout stay stable and in_ready stays 0. Then raise out_ready -> IDLE, and in_ready=1 next cycle.
REQ-036 Assert rst_n=0 after 2 RUN cycles -> all outputs 0 immediately. Release -> in_ready=1 after one edge, and no out_valid pulse.
REQ-037 With OVF_FLAG_EN: a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1. With OVF_FLAG_EN: a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
REQ-038 Exhaustive WIDTH=4 sweep, a,b in 0..15, cin in {0,1}: {cout,sum} = a+b+cin, with latency 1 edge for each operation.
